// File: rtl/fifo_pkg.sv
// Shared sizing helpers and status record for the synchronous and asynchronous FIFOs.
package fifo_pkg;

  // Count field is sized for the largest FIFO in the codebase; instances use the low bits.
  localparam int unsigned CountFieldWidth = 16;

  function automatic int unsigned addr_width(input int unsigned data_width,
                                             input int unsigned depth);
    return $clog2(data_width * depth);
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic [CountFieldWidth-1:0] count;
    logic                       empty;
    logic                       full;
    logic                       almost_full;
    logic                       overflow;
    logic                       underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_pointer.sv
// Wrap-bit pointer: slot index in the low bits, lap parity in the MSB, plus the slot's bit offset.
module fifo_pointer
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     increment,
  input  logic                                     clear,
  output logic [count_width(DEPTH)-1:0]            ptr,
  output logic [$clog2(DEPTH)-1:0]                 slot,
  output logic [addr_width(DATA_WIDTH, DEPTH)-1:0] bit_offset
);

  localparam int unsigned PtrWidth  = count_width(DEPTH);
  localparam int unsigned SlotWidth = $clog2(DEPTH);
  localparam int unsigned AddrWidth = addr_width(DATA_WIDTH, DEPTH);

  logic [PtrWidth-1:0] ptr_q;

  // DEPTH is a power of two, so natural overflow gives modulo 2*DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (clear) begin
      ptr_q <= '0;
    end else if (increment) begin
      ptr_q <= ptr_q + PtrWidth'(1);
    end
  end

  assign ptr        = ptr_q;
  assign slot       = ptr_q[SlotWidth-1:0];
  assign bit_offset = AddrWidth'(slot) * AddrWidth'(DATA_WIDTH);

endmodule

// File: rtl/fifo_controller.sv
// Single-clock FWFT sequencer for fifo_memory: pointers, address generation, handshakes, status.
module fifo_controller
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned DEPTH             = 8,
  parameter int unsigned ALMOST_FULL_LEVEL = DEPTH - 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     flush,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     mem_write_enable,
  output logic [addr_width(DATA_WIDTH, DEPTH)-1:0] mem_write_address,
  output logic [addr_width(DATA_WIDTH, DEPTH)-1:0] mem_read_address,
  output logic [count_width(DEPTH)-1:0]            count,
  output logic                                     empty,
  output logic                                     full,
  output logic                                     almost_full,
  output logic                                     overflow,
  output logic                                     underflow
);

  localparam int unsigned CountWidth = count_width(DEPTH);
  localparam int unsigned SlotWidth  = $clog2(DEPTH);

  fifo_status_t status_q, status_d;

  logic                  wr_fire, rd_fire;
  logic [CountWidth-1:0] wr_ptr, rd_ptr;
  logic [SlotWidth-1:0]  wr_slot, rd_slot;

  assign in_ready  = !status_q.full;
  assign out_valid = !status_q.empty;

  // Flush discards same-cycle fires; reset gating keeps the write strobe low while held.
  assign wr_fire = in_valid && in_ready && !flush && !reset;
  assign rd_fire = out_valid && out_ready && !flush;

  assign mem_write_enable = wr_fire;

  fifo_pointer #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_pointer (
    .clk        (clk),
    .reset      (reset),
    .increment  (wr_fire),
    .clear      (flush),
    .ptr        (wr_ptr),
    .slot       (wr_slot),
    .bit_offset (mem_write_address)
  );

  fifo_pointer #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_pointer (
    .clk        (clk),
    .reset      (reset),
    .increment  (rd_fire),
    .clear      (flush),
    .ptr        (rd_ptr),
    .slot       (rd_slot),
    .bit_offset (mem_read_address)
  );

  always_comb begin
    status_d = status_q;
    if (flush) begin
      status_d.count     = '0;
      status_d.overflow  = 1'b0;
      status_d.underflow = 1'b0;
    end else begin
      status_d.count     = status_q.count + CountFieldWidth'(wr_fire)
                                          - CountFieldWidth'(rd_fire);
      status_d.overflow  = status_q.overflow  || (in_valid && status_q.full);
      status_d.underflow = status_q.underflow || (out_ready && status_q.empty);
    end
    status_d.empty       = (status_d.count == '0);
    status_d.full        = (status_d.count == CountFieldWidth'(DEPTH));
    status_d.almost_full = (status_d.count >= CountFieldWidth'(ALMOST_FULL_LEVEL));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_q.count       <= '0;
      status_q.empty       <= 1'b1;
      status_q.full        <= 1'b0;
      status_q.almost_full <= 1'b0;
      status_q.overflow    <= 1'b0;
      status_q.underflow   <= 1'b0;
    end else begin
      status_q <= status_d;
    end
  end

  assign count       = status_q.count[CountWidth-1:0];
  assign empty       = status_q.empty;
  assign full        = status_q.full;
  assign almost_full = status_q.almost_full;
  assign overflow    = status_q.overflow;
  assign underflow   = status_q.underflow;

  // The count-derived flags must agree with the wrap-bit pointer definitions.
  full_matches_ptrs: assert property (@(posedge clk) disable iff (reset)
    status_q.full == ((wr_slot == rd_slot) && (wr_ptr[SlotWidth] != rd_ptr[SlotWidth])));
  empty_matches_ptrs: assert property (@(posedge clk) disable iff (reset)
    status_q.empty == (wr_ptr == rd_ptr));

endmodule

// File: doc/fifo_controller.md
# fifo_controller

Single-clock sequencer for the `fifo_memory` storage array. It owns the write and read pointers, generates the memory's `write_enable`, `write_address` and `read_address`, and presents valid/ready handshakes to a producer and a consumer. It also reports occupancy, almost-full and sticky error status. It sits between the print-mechanism capture logic (producer) and the host-side readout (consumer) wherever both run on one clock.

## Interface

Parameters:

- `DATA_WIDTH`, default 8: word width; must match the attached memory.
- `DEPTH`, default 8: number of words; power of two, ≥ 2.
- `ALMOST_FULL_LEVEL`, default `DEPTH-2`: `almost_full` asserts when `count` ≥ this value.

Ports:

- `clk` in 1: sole clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `flush` in 1: synchronous clear of pointers, count and error flags.
- `in_valid` in 1: producer offers a word this cycle.
- `in_ready` out 1: controller accepts the word this cycle.
- `out_valid` out 1: head word is available on memory `read_data`.
- `out_ready` in 1: consumer takes the head word this cycle.
- `mem_write_enable` out 1: to memory `write_enable`.
- `mem_write_address` out `ADDR_WIDTH`: to memory `write_address`, as a bit offset.
- `mem_read_address` out `ADDR_WIDTH`: to memory `read_address`, as a bit offset.
- `count` out `$clog2(DEPTH)+1`: words stored, 0..DEPTH.
- `empty` out 1: `count == 0`.
- `full` out 1: `count == DEPTH`.
- `almost_full` out 1: `count` ≥ `ALMOST_FULL_LEVEL`.
- `overflow` out 1: sticky; set when `in_valid` is high while `full`.
- `underflow` out 1: sticky; set when `out_ready` is high while `empty`.

`ADDR_WIDTH = $clog2(DATA_WIDTH*DEPTH)`.

## Operation

- **Pointers.** Write and read pointers are `$clog2(DEPTH)+1` bits each, with an extra wrap bit. The slot index is the low bits.
  - `full`: slot indices are equal and wrap bits differ.
  - `empty`: both pointers are equal.
- **Address generation.** `mem_write_address = wr_slot*DATA_WIDTH` and `mem_read_address = rd_slot*DATA_WIDTH`. The memory indexes by bit offset.
  - Each product is computed at `ADDR_WIDTH` bits; no truncation is permitted.
  - Both addresses are purely registered pointer functions, so they are glitch-free.
- **Handshakes.**
  - `in_ready = !full` (combinational from state only).
  - Write fires on `in_valid && in_ready`. `mem_write_enable` equals the write fire, combinationally.
  - `out_valid = !empty`.
  - Read fires on `out_valid && out_ready`.
- **Simultaneous read and write.** Both fire and both pointers advance. `count` is unchanged.
- **Full with a simultaneous read.** `in_ready` is still 0; no write occurs that cycle. There is no pass-through.
- **Empty with a simultaneous write.** No read occurs. The data appears on `out_valid` the following cycle. There is no bypass.
- **Wrap-around.** Pointers increment modulo `2*DEPTH`. The slot wraps from `DEPTH-1` to 0 and the wrap bit toggles.
- **Flush.**
  - Pointers, `count` and both sticky flags go to 0.
  - Any fire in the same cycle is discarded, and the overflow/underflow sets from that cycle are suppressed.
  - Memory contents are not cleared.
- **Errors.** Overflow and underflow attempts never move the pointers. Their flags stay set until `flush` or `reset`.

## Timing

- **Reset values.** While `reset` is high:
  - `in_ready` = 1 and `empty` = 1.
  - `out_valid`, `full`, `almost_full`, `overflow`, `underflow` and `mem_write_enable` = 0.
  - `count` = 0, `mem_write_address` = 0 and `mem_read_address` = 0.
- **Reset mid-operation.** Takes effect immediately and asynchronously. In-flight handshakes are dropped.
- **Write latency.** A word accepted at edge N is visible at the head, with `out_valid` = 1, after edge N.
  - It is captured by the memory at that same edge N.
- **Read latency.** `read_data` is combinational on `mem_read_address`, so there is zero-cycle read latency from `out_valid`. This is first-word-fall-through.
- **Status outputs.** `count`, `full`, `empty` and `almost_full` are registered and update one edge after the fire.
- **Control paths.** `in_ready` and `out_valid` depend only on registered state. There is no combinational path from `in_valid` or `out_ready` to them.

## Structure

- **Package `fifo_pkg`.**
  - `ADDR_WIDTH` and count-width helper functions.
  - A `fifo_status_t` packed struct holding `count`, `empty`, `full`, `almost_full`, `overflow` and `underflow`.
  - Shared with the async FIFO.
- **Sub-module `fifo_pointer`.** One natural sub-module, instantiated twice (write and read).
  - Wrap-bit counter with `increment`, `clear`, `slot` and `ptr` outputs, plus a `bit_offset` output equal to slot × `DATA_WIDTH`.
- **Top level.** Holds the handshake logic, count register, flags and status.

## Test plan

- **Reset state.** Assert `reset` for 3 cycles, then release → `empty`=1, `in_ready`=1, `count`=0, both addresses 0, `mem_write_enable`=0.
- **Fill and overflow.** Defaults (DEPTH=8, W=8); write `0x11`..`0x88` back-to-back → `count`=8, `full`=1, `in_ready`=0. `almost_full` rises once `count` reaches 6. A 9th `in_valid` sets `overflow` and leaves pointers unchanged.
- **Drain, FWFT and underflow.** From full, hold `out_ready` → reads `0x11`..`0x88` in order, `mem_read_address` steps 0,8,…,56, then `empty`=1. One more `out_ready` sets `underflow`.
- **Wrap-around with concurrency.** Write 5 words and read 5 words; then hold `in_valid` and `out_ready` together for 20 cycles with a data ramp → `count` stays constant at 0→1 steady state and data order is preserved. `mem_write_address` wraps 56→0.
- **Flush.** With 4 stored, `overflow` set, and `flush` asserted together with `in_valid` → next cycle `count`=0, `empty`=1, `overflow`=0, and no write is recorded.
- **Asynchronous reset mid-operation.** Assert `reset` mid-cycle during streaming → outputs reach reset values before the next edge, and the FIFO restarts cleanly from empty.
